// File: rtl/ram_sdp_stream_pkg.sv
// Shared types and helpers for the ram_sdp_stream block.
package ram_sdp_stream_pkg;

  typedef enum logic {
    COLL_WRITE_FIRST,
    COLL_READ_FIRST
  } coll_mode_e;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  localparam int unsigned MAX_READ_LATENCY = 8;
  localparam int unsigned PARITY_MAX_WIDTH = 64;

  // Even parity bit: stored bit makes the lane plus parity hold an even number of ones.
  function automatic logic even_parity(input logic [PARITY_MAX_WIDTH-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/ram_sdp_stream_fifo.sv
// Response buffer for ram_sdp_stream: small synchronous FIFO, any depth >= 2,
// combinational head read. Overflow is prevented upstream by the credit counter.
module ram_sdp_stream_fifo #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned PTRW = $clog2(DEPTH),
  localparam int unsigned CNTW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             arstn_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTRW-1:0]  wptr_q, wptr_d;
  logic [PTRW-1:0]  rptr_q, rptr_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_i) begin
      wptr_d = (wptr_q == PTRW'(DEPTH - 1)) ? '0 : wptr_q + PTRW'(1);
    end
    if (pop_i) begin
      rptr_d = (rptr_q == PTRW'(DEPTH - 1)) ? '0 : rptr_q + PTRW'(1);
    end
    unique case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CNTW'(1);
      2'b01:   cnt_d = cnt_q - CNTW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wptr_q] <= data_i;
    end
  end

  assign data_o  = mem_q[rptr_q];
  assign full_o  = (cnt_q == CNTW'(DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/ram_sdp_stream.sv
// Simple-dual-port byte-write RAM with a credit-protected valid/ready read stream.
// Optional per-lane even parity storage and checking: define RAM_SDP_STREAM_PARITY_EN.
module ram_sdp_stream
  import ram_sdp_stream_pkg::*;
#(
  parameter int unsigned MEM_DEPTH    = 64,
  parameter int unsigned BYTE_WIDTH   = 8,
  parameter int unsigned BYTE_NUM     = 4,
  parameter int unsigned MEM_WIDTH    = BYTE_WIDTH * BYTE_NUM,
  parameter int unsigned READ_LATENCY = 2,
  parameter string       COLL_MODE    = "write_first",
  parameter int unsigned INIT_CLEAR   = 1,
  parameter string       RAM_STYLE    = "block"
) (
  input  logic                         clk_i,
  input  logic                         arstn_i,
  input  logic                         wr_en_i,
  input  logic [BYTE_NUM-1:0]          wr_be_i,
  input  logic [$clog2(MEM_DEPTH)-1:0] wr_addr_i,
  input  logic [MEM_WIDTH-1:0]         wr_data_i,
  output logic                         wr_ready_o,
  input  logic                         rd_req_valid_i,
  output logic                         rd_req_ready_o,
  input  logic [$clog2(MEM_DEPTH)-1:0] rd_addr_i,
  output logic                         rd_valid_o,
  input  logic                         rd_ready_i,
  output logic [MEM_WIDTH-1:0]         rd_data_o,
  output logic                         init_done_o
`ifdef RAM_SDP_STREAM_PARITY_EN
  ,
  output logic [BYTE_NUM-1:0]          rd_perr_o
`endif
);

  localparam int unsigned AW        = $clog2(MEM_DEPTH);
  localparam int unsigned OUT_DEPTH = READ_LATENCY + 1;
  localparam int unsigned CW        = $clog2(OUT_DEPTH + 1);
  localparam coll_mode_e  COLL      = (COLL_MODE == "read_first") ? COLL_READ_FIRST
                                                                  : COLL_WRITE_FIRST;
`ifdef RAM_SDP_STREAM_PARITY_EN
  localparam int unsigned PW = MEM_WIDTH + BYTE_NUM;
`else
  localparam int unsigned PW = MEM_WIDTH;
`endif

  if (MEM_WIDTH != BYTE_WIDTH * BYTE_NUM) begin : g_chk_width
    $error("MEM_WIDTH must equal BYTE_WIDTH*BYTE_NUM");
  end
  if (MEM_DEPTH < 2 || (MEM_DEPTH & (MEM_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("MEM_DEPTH must be a power of two >= 2");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_chk_lat
    $error("READ_LATENCY out of range 1..8");
  end
  if (COLL_MODE != "write_first" && COLL_MODE != "read_first") begin : g_chk_coll
    $error("COLL_MODE must be \"write_first\" or \"read_first\"");
  end
  if (RAM_STYLE == "") begin : g_chk_style
    $error("RAM_STYLE must not be empty");
  end

  (* ram_style = RAM_STYLE *) logic [MEM_WIDTH-1:0] mem_q [MEM_DEPTH];
`ifdef RAM_SDP_STREAM_PARITY_EN
  logic [BYTE_NUM-1:0] par_q [MEM_DEPTH];
`endif

  state_e              state_q;
  logic [AW-1:0]       clr_addr_q;
  logic                init_done_q;
  logic [CW-1:0]       credits_q, credits_d;
  logic [READ_LATENCY-1:0] pvld_q;
  logic [PW-1:0]       pipe_q [READ_LATENCY];

  logic                wr_fire, rd_fire, pop;
  logic                ram_we;
  logic [BYTE_NUM-1:0] ram_be;
  logic [AW-1:0]       ram_addr;
  logic [MEM_WIDTH-1:0] ram_wdata;
  logic [MEM_WIDTH-1:0] rd_word;
  logic [PW-1:0]       pipe_in;
  logic [PW-1:0]       fifo_din, fifo_dout;
  logic                fifo_full, fifo_empty;

  assign init_done_o    = init_done_q;
  assign wr_ready_o     = init_done_q;
  assign rd_req_ready_o = init_done_q & (credits_q != '0);
  assign wr_fire        = wr_en_i & init_done_q;
  assign rd_fire        = rd_req_valid_i & rd_req_ready_o;
  assign rd_valid_o     = ~fifo_empty;
  assign pop            = rd_valid_o & rd_ready_i;

  // Clear sweep: INIT writes one zero word per cycle, done flag follows RUN by a cycle.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q     <= ST_INIT;
      clr_addr_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_INIT: begin
          if (INIT_CLEAR == 0) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end else begin
            clr_addr_q <= clr_addr_q + AW'(1);
            if (clr_addr_q == AW'(MEM_DEPTH - 1)) begin
              state_q <= ST_RUN;
            end
          end
        end
        ST_RUN: init_done_q <= 1'b1;
        default: state_q <= ST_INIT;
      endcase
    end
  end

  always_comb begin
    ram_we    = wr_fire;
    ram_be    = wr_be_i;
    ram_addr  = wr_addr_i;
    ram_wdata = wr_data_i;
    if (state_q == ST_INIT && INIT_CLEAR != 0) begin
      ram_we    = 1'b1;
      ram_be    = '1;
      ram_addr  = clr_addr_q;
      ram_wdata = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (ram_we) begin
      for (int unsigned b = 0; b < BYTE_NUM; b++) begin
        if (ram_be[b]) begin
          mem_q[ram_addr][b*BYTE_WIDTH +: BYTE_WIDTH] <= ram_wdata[b*BYTE_WIDTH +: BYTE_WIDTH];
`ifdef RAM_SDP_STREAM_PARITY_EN
          par_q[ram_addr][b] <=
            even_parity(PARITY_MAX_WIDTH'(ram_wdata[b*BYTE_WIDTH +: BYTE_WIDTH]));
`endif
        end
      end
    end
  end

  // Write-first bypass merges only the enabled lanes of a same-address write.
  always_comb begin
    rd_word = mem_q[rd_addr_i];
`ifdef RAM_SDP_STREAM_PARITY_EN
    pipe_in = {par_q[rd_addr_i], mem_q[rd_addr_i]};
`else
    pipe_in = mem_q[rd_addr_i];
`endif
    if (COLL == COLL_WRITE_FIRST && wr_fire && (wr_addr_i == rd_addr_i)) begin
      for (int unsigned b = 0; b < BYTE_NUM; b++) begin
        if (wr_be_i[b]) begin
          rd_word[b*BYTE_WIDTH +: BYTE_WIDTH] = wr_data_i[b*BYTE_WIDTH +: BYTE_WIDTH];
`ifdef RAM_SDP_STREAM_PARITY_EN
          pipe_in[MEM_WIDTH+b] =
            even_parity(PARITY_MAX_WIDTH'(wr_data_i[b*BYTE_WIDTH +: BYTE_WIDTH]));
`endif
        end
      end
    end
    pipe_in[MEM_WIDTH-1:0] = rd_word;
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      pvld_q <= '0;
    end else begin
      pvld_q[0] <= rd_fire;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        pvld_q[i] <= pvld_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    pipe_q[0] <= pipe_in;
    for (int unsigned i = 1; i < READ_LATENCY; i++) begin
      pipe_q[i] <= pipe_q[i-1];
    end
  end

`ifdef RAM_SDP_STREAM_PARITY_EN
  always_comb begin
    fifo_din = pipe_q[READ_LATENCY-1];
    for (int unsigned b = 0; b < BYTE_NUM; b++) begin
      fifo_din[MEM_WIDTH+b] = pipe_q[READ_LATENCY-1][MEM_WIDTH+b] ^
        even_parity(PARITY_MAX_WIDTH'(pipe_q[READ_LATENCY-1][b*BYTE_WIDTH +: BYTE_WIDTH]));
    end
  end
  assign rd_perr_o = fifo_empty ? '0 : fifo_dout[PW-1:MEM_WIDTH];
`else
  assign fifo_din = pipe_q[READ_LATENCY-1];
`endif

  assign rd_data_o = fifo_empty ? '0 : fifo_dout[MEM_WIDTH-1:0];

  always_comb begin
    credits_d = credits_q;
    unique case ({rd_fire, pop})
      2'b10:   credits_d = credits_q - CW'(1);
      2'b01:   credits_d = credits_q + CW'(1);
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      credits_q <= CW'(OUT_DEPTH);
    end else begin
      credits_q <= credits_d;
    end
  end

  ram_sdp_stream_fifo #(
    .DEPTH (OUT_DEPTH),
    .WIDTH (PW)
  ) u_fifo (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .push_i  (pvld_q[READ_LATENCY-1]),
    .data_i  (fifo_din),
    .pop_i   (pop),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!arstn_i)
    !(pvld_q[READ_LATENCY-1] && fifo_full && !pop));

endmodule

// File: doc/ram_sdp_stream.md
Name: ram_sdp_stream

Overview:
- Single-clock simple-dual-port byte-write RAM with a valid/ready read interface.
- Read requests enter a fixed-latency RAM read pipeline. Responses land in a small credit-protected output buffer, so downstream backpressure never stalls or drops in-flight reads.
- Optional power-on clear sweep and per-address write/read collision policy.
- Sits between DMA/packet engines and on-chip storage where consumers apply backpressure.

Parameters:
- MEM_DEPTH, 64, number of words; power of two, >= 2
- BYTE_WIDTH, 8, bits per byte lane
- BYTE_NUM, 4, byte lanes per word
- MEM_WIDTH, BYTE_WIDTH*BYTE_NUM, word width; elaboration error if it differs
- READ_LATENCY, 2, request-to-buffer latency in cycles; 1..8
- COLL_MODE, "write_first", same-cycle same-address policy: "write_first" or "read_first"; anything else is an elaboration error
- INIT_CLEAR, 1, 1 = zero all words after reset before accepting traffic
- RAM_STYLE, "block", synthesis attribute on storage array

Ports:
- clk_i  in  1  clock
- arstn_i  in  1  asynchronous active-low reset
- wr_en_i  in  1  write strobe; honoured only while wr_ready_o=1
- wr_be_i  in  BYTE_NUM  byte enables
- wr_addr_i  in  $clog2(MEM_DEPTH)  write address
- wr_data_i  in  MEM_WIDTH  write data
- wr_ready_o  out  1  high when writes are accepted (equals init_done_o)
- rd_req_valid_i  in  1  read request valid
- rd_req_ready_o  out  1  read request ready
- rd_addr_i  in  $clog2(MEM_DEPTH)  read address
- rd_valid_o  out  1  response valid
- rd_ready_i  in  1  response ready
- rd_data_o  out  MEM_WIDTH  response data
- init_done_o  out  1  clear sweep complete

Behaviour:
- Reset (arstn_i low, asynchronous):
  - rd_valid_o=0, rd_data_o=0, init_done_o=0, rd_req_ready_o=0.
  - Pipeline valids cleared, buffer emptied, credits=OUT_DEPTH.
  - RAM contents are not reset.
- Clear FSM states: INIT -> RUN.
  - INIT_CLEAR=1: INIT writes zero to address 0..MEM_DEPTH-1, one per cycle, starting the first clock after reset release. init_done_o rises the cycle after address MEM_DEPTH-1 is written.
  - INIT_CLEAR=0: RUN is entered on the first clock after reset release.
  - RUN is absorbing. Reset mid-sweep restarts the sweep at address 0.
- Writes:
  - On a rising edge with wr_en_i & wr_ready_o, byte lane i is written iff wr_be_i[i].
  - wr_be_i=0 is a no-op.
  - Writes never stall in RUN.
- Read buffer and credits:
  - OUT_DEPTH = READ_LATENCY+1.
  - credits counts free buffer slots minus in-flight requests.
  - rd_req_ready_o = init_done_o & (credits != 0).
  - A request is accepted on rd_req_valid_i & rd_req_ready_o. Accepted request: credits-1. Response pop (rd_valid_o & rd_ready_i): credits+1. Both in one cycle: credits unchanged.
- Read latency:
  - An accepted request's data is pushed to the buffer READ_LATENCY cycles later.
  - rd_valid_o rises the next cycle when the buffer was empty.
  - Back-to-back requests yield one response per cycle while rd_ready_i=1.
  - Responses return strictly in request order.
- Collision (same-cycle write and accepted read, same address):
  - write_first: enabled lanes return new data, disabled lanes return old data.
  - read_first: all lanes return old data.
  - Different addresses: no interaction.
- Output stability:
  - While rd_valid_o & !rd_ready_i, rd_data_o and rd_valid_o hold.
  - The buffer never overflows; this is guaranteed by credits.
  - Overflow is an assertion failure in simulation.
- Requests during INIT are not accepted (rd_req_ready_o=0).

Optional Feature:
- Macro: RAM_SDP_STREAM_PARITY_EN.
- Defined:
  - One even-parity bit is stored per byte lane, computed at write time. The clear sweep stores parity of zero.
  - Output rd_perr_o (BYTE_NUM bits) travels with each response, aligned with rd_valid_o/rd_data_o. Bit i=1 flags a lane-i mismatch on read.
  - Reset value of rd_perr_o is 0.
- Undefined: no parity storage, and port rd_perr_o is absent.

Decomposition:
- Package ram_sdp_stream_pkg:
  - coll_mode_e enum (COLL_WRITE_FIRST, COLL_READ_FIRST)
  - state_e (ST_INIT, ST_RUN)
  - MAX_READ_LATENCY=8
  - function even_parity.
- Sub-module ram_sdp_stream_fifo:
  - Synchronous FIFO of depth OUT_DEPTH, width MEM_WIDTH (+BYTE_NUM with parity).
  - Asynchronous active-low reset, push/pop, full/empty.
  - The top level holds the RAM array, clear FSM, latency pipeline and credit counter.

Test Plan:
- Clear sweep, INIT_CLEAR=1, MEM_DEPTH=64:
  - Release reset -> init_done_o rises exactly 65 cycles later.
  - Reads of addresses 0, 31, 63 return 0x00000000.
- Byte enables:
  - Write addr 5 with 0xAABBCCDD, be=4'b1111.
  - Then write 0x11223344 with be=4'b0101.
  - Read addr 5 -> 0xAA22CC44, rd_valid_o rising READ_LATENCY+1 cycles after the request.
- Backpressure, READ_LATENCY=2:
  - Hold rd_ready_i=0 while issuing requests every cycle -> exactly 3 accepted, then rd_req_ready_o=0.
  - Release -> 3 responses in order, no loss or duplication.
- Collision:
  - Addr 9 holds 0x12345678. Same cycle: write 0xFFFFFFFF be=4'b0011 and read addr 9.
  - write_first returns 0x1234FFFF; read_first returns 0x12345678.
- Reset mid-operation:
  - Assert arstn_i during INIT (address 20) and again with 2 responses buffered.
  - rd_valid_o=0 immediately, the sweep restarts at 0, and credits return to OUT_DEPTH.
- Parity (macro defined):
  - Force-flip bit 9 of stored word at addr 3 via hierarchical deposit, then read -> rd_perr_o=4'b0010 with the response.
